// File: rtl/cfg_dprio_shadow_status_bank_pkg.sv
// Purpose  : shared definitions for the DPRIO shadow status bank (per-channel FSM encoding).
// Latency  : n/a (definitions only).
// Backpr.  : n/a (definitions only).
package cfg_dprio_shadow_status_bank_pkg;

    // Per-channel handshake FSM encoding; the state bit doubles as the ack output.
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_ACK  = 1'b1;

endpackage : cfg_dprio_shadow_status_bank_pkg

// File: rtl/cdclib_bitsync2.sv
// Purpose  : DWIDTH independent 2-flop bit synchronisers into the clk domain.
// Latency  : 2 clk edges from the input being sampled to the synchronised output.
// Backpr.  : none; level signals only, no flow control.
// Ports    : clk, rst_n (async active-low), data_in[DWIDTH] (async), data_out[DWIDTH] (sync).
module cdclib_bitsync2 #(
    parameter int              DWIDTH       = 1,
    parameter logic            RESET_VAL    = 1'b0,
    parameter int              CLK_FREQ_MHZ = 250,
    parameter int              TOGGLE_TYPE  = 1,
    parameter int              VID          = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out
);

    logic [DWIDTH-1:0] r_meta;
    logic [DWIDTH-1:0] r_sync;

    // Frequency/toggle/VID are library attributes carried for the timing flow;
    // the 2-flop structure is identical for every legal combination.
    if (CLK_FREQ_MHZ < 1 || TOGGLE_TYPE < 0 || VID < 0) begin : g_unsupported_cfg
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= {DWIDTH{RESET_VAL}};
            r_sync <= {DWIDTH{RESET_VAL}};
        end else begin
            r_meta <= data_in;
            r_sync <= r_meta;
        end
    end

    assign data_out = r_sync;

endmodule : cdclib_bitsync2

// File: rtl/cfg_dprio_shadow_status_bank.sv
// Purpose  : per-channel shadow copy of live status, captured on a DPRIO 4-phase request, with sticky bits and a changed flag.
// Latency  : ack rises/falls on the 3rd clk edge after write_en is sampled high/low; capture on the ack-rise edge.
// Backpr.  : DPRIO holds write_en until ack is seen; one capture per request, none while ack is held.
// Ports    : clk, rst_n (async active-low); stat_data_in/stat_data_out packed NUM_CH x DATA_WIDTH;
//            write_en (async) / write_en_ack per channel; stat_changed per channel.
module cfg_dprio_shadow_status_bank
    import cfg_dprio_shadow_status_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    NUM_CH       = 4,
    parameter int                    CLK_FREQ_MHZ = 250,
    parameter int                    TOGGLE_TYPE  = 1,
    parameter int                    VID          = 1,
    parameter logic [DATA_WIDTH-1:0] STICKY_MASK  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] stat_data_in,
    input  logic [NUM_CH-1:0]            write_en,
    output logic [NUM_CH-1:0]            write_en_ack,
    output logic [NUM_CH*DATA_WIDTH-1:0] stat_data_out,
    output logic [NUM_CH-1:0]            stat_changed
);

    logic [NUM_CH-1:0] w_write_en_sync;

    cdclib_bitsync2 #(
        .DWIDTH       (NUM_CH),
        .RESET_VAL    (1'b0),
        .CLK_FREQ_MHZ (CLK_FREQ_MHZ),
        .TOGGLE_TYPE  (TOGGLE_TYPE),
        .VID          (VID)
    ) u_write_en_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (write_en),
        .data_out (w_write_en_sync)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                  r_state;
        logic                  w_state_nxt;
        logic                  w_capture_en;
        logic [DATA_WIDTH-1:0] w_live;
        logic [DATA_WIDTH-1:0] w_capture;
        logic [DATA_WIDTH-1:0] r_accum;
        logic [DATA_WIDTH-1:0] r_out;
        logic                  r_changed;

        assign w_live = stat_data_in[c*DATA_WIDTH +: DATA_WIDTH];

        // r_accum only ever holds sticky positions, so a plain OR gives
        // live for non-sticky bits and live|history for sticky bits.
        assign w_capture = w_live | r_accum;

        always_comb begin
            w_state_nxt  = r_state;
            w_capture_en = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_write_en_sync[c]) begin
                        w_state_nxt  = ST_ACK;
                        w_capture_en = 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!w_write_en_sync[c]) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= ST_IDLE;
                r_accum   <= '0;
                r_out     <= '0;
                r_changed <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                if (w_capture_en) begin
                    r_out     <= w_capture;
                    r_changed <= (w_capture != r_out);
                    // Bits high on the capture edge are already in w_capture,
                    // so the accumulator restarts empty.
                    r_accum   <= '0;
                end else begin
                    r_accum   <= r_accum | (w_live & STICKY_MASK);
                end
            end
        end

        assign write_en_ack[c]                          = r_state;
        assign stat_data_out[c*DATA_WIDTH +: DATA_WIDTH] = r_out;
        assign stat_changed[c]                          = r_changed;
    end

endmodule : cfg_dprio_shadow_status_bank

// File: tb/tb_cfg_dprio_shadow_status_bank.sv
// Purpose  : directed self-checking bench for cfg_dprio_shadow_status_bank (NUM_CH=4, bit0 sticky).
// Latency  : checks ack timing at exactly the 3rd edge after a write_en change.
// Backpr.  : drives the DPRIO side of the 4-phase handshake.
module tb_cfg_dprio_shadow_status_bank;

    localparam int DW = 16;
    localparam int NC = 4;

    logic             clk;
    logic             rst_n;
    logic [NC*DW-1:0] stat_data_in;
    logic [NC-1:0]    write_en;
    logic [NC-1:0]    write_en_ack;
    logic [NC*DW-1:0] stat_data_out;
    logic [NC-1:0]    stat_changed;

    int checks = 0;
    int errors = 0;

    cfg_dprio_shadow_status_bank #(
        .DATA_WIDTH   (DW),
        .NUM_CH       (NC),
        .CLK_FREQ_MHZ (250),
        .TOGGLE_TYPE  (1),
        .VID          (1),
        .STICKY_MASK  (16'h0001)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stat_data_in  (stat_data_in),
        .write_en      (write_en),
        .write_en_ack  (write_en_ack),
        .stat_data_out (stat_data_out),
        .stat_changed  (stat_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] val);
        stat_data_in[ch*DW +: DW] = val;
    endtask

    // Full request/ack cycle on one channel with exact-latency ack checks.
    task automatic do_capture(input int ch, input string tag);
        write_en[ch] = 1'b1;
        repeat (3) tick();
        check({tag, "_ack_rise"}, 64'(write_en_ack[ch]), 64'd1);
        write_en[ch] = 1'b0;
        repeat (3) tick();
        check({tag, "_ack_fall"}, 64'(write_en_ack[ch]), 64'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        stat_data_in = '0;
        write_en     = '0;
        repeat (2) tick();
        check("rst_ack",     64'(write_en_ack),  64'h0);
        check("rst_out",     stat_data_out,      64'h0);
        check("rst_changed", 64'(stat_changed),  64'h0);
        rst_n = 1'b1;
        tick();

        // Basic capture on ch1 with exact ack latency.
        set_ch(1, 16'hA5A5);
        write_en[1] = 1'b1;
        tick();
        check("c1_ack_e1", 64'(write_en_ack), 64'h0);
        tick();
        check("c1_ack_e2", 64'(write_en_ack), 64'h0);
        tick();
        check("c1_ack_e3",  64'(write_en_ack), 64'h2);
        check("c1_out",     stat_data_out,     64'h0000_0000_A5A5_0000);
        check("c1_changed", 64'(stat_changed), 64'h2);

        // No capture while ack held, then exact fall latency.
        set_ch(1, 16'h1234);
        repeat (2) tick();
        check("c1_hold_out", stat_data_out, 64'h0000_0000_A5A5_0000);
        write_en[1] = 1'b0;
        repeat (2) tick();
        check("c1_fall_e2", 64'(write_en_ack), 64'h2);
        tick();
        check("c1_fall_e3", 64'(write_en_ack), 64'h0);
        do_capture(1, "c1_req2");
        check("c1_req2_out",     stat_data_out,     64'h0000_0000_1234_0000);
        check("c1_req2_changed", 64'(stat_changed), 64'h2);

        // Sticky bit0 pulse on ch0 is remembered; non-sticky bit4 pulse is not.
        set_ch(0, 16'h0011);
        tick();
        set_ch(0, 16'h0000);
        repeat (2) tick();
        do_capture(0, "s0_cap1");
        check("s0_cap1_out",     stat_data_out,     64'h0000_0000_1234_0001);
        check("s0_cap1_changed", 64'(stat_changed), 64'h3);
        do_capture(0, "s0_cap2");
        check("s0_cap2_out",     stat_data_out,     64'h0000_0000_1234_0000);
        check("s0_cap2_changed", 64'(stat_changed), 64'h3);

        // Identical data captured twice on ch3.
        set_ch(3, 16'h00FF);
        do_capture(3, "d3_cap1");
        check("d3_cap1_out",     stat_data_out,     64'h00FF_0000_1234_0000);
        check("d3_cap1_changed", 64'(stat_changed), 64'hB);
        do_capture(3, "d3_cap2");
        check("d3_cap2_changed", 64'(stat_changed), 64'h3);

        // Simultaneous requests on ch0 and ch3.
        set_ch(0, 16'h0F0F);
        set_ch(3, 16'hBEEF);
        write_en = 4'b1001;
        repeat (2) tick();
        check("sim_ack_e2", 64'(write_en_ack), 64'h0);
        tick();
        check("sim_ack_e3",  64'(write_en_ack), 64'h9);
        check("sim_out",     stat_data_out,     64'hBEEF_0000_1234_0F0F);
        check("sim_changed", 64'(stat_changed), 64'hB);
        write_en = 4'b0000;
        repeat (3) tick();
        check("sim_ack_fall", 64'(write_en_ack), 64'h0);

        // Reset mid-handshake on ch2, then a fresh capture after release.
        set_ch(2, 16'h5555);
        write_en[2] = 1'b1;
        repeat (3) tick();
        check("r2_ack", 64'(write_en_ack), 64'h4);
        check("r2_out", stat_data_out,     64'hBEEF_5555_1234_0F0F);
        rst_n = 1'b0;
        #2;
        check("r2_async_ack",     64'(write_en_ack), 64'h0);
        check("r2_async_out",     stat_data_out,     64'h0);
        check("r2_async_changed", 64'(stat_changed), 64'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("r2_rel_e2", 64'(write_en_ack), 64'h0);
        tick();
        check("r2_rel_e3",     64'(write_en_ack), 64'h4);
        check("r2_rel_out",    stat_data_out,     64'h0000_5555_0000_0000);
        check("r2_rel_changed", 64'(stat_changed), 64'h4);
        write_en[2] = 1'b0;
        repeat (3) tick();
        check("r2_ack_fall", 64'(write_en_ack), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cfg_dprio_shadow_status_bank
